// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pixel pipeline stages.
package pipe_pkg;
  localparam int DEF_QQ = 12;
  localparam int DEF_SS = 11;
  localparam int DEF_RW = 16;
  localparam int DEF_RF = 12;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} div_st_t;
endpackage

// File: rtl/pipe_div_step.sv
// One restoring-division iteration: shift in a dividend bit, compare, conditionally subtract.
module pipe_div_step #(
  parameter int W = 23
)(
  input  logic [W-1:0] r_i,
  input  logic         din_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] r_o,
  output logic         q_o
);
  logic [W:0] rs;

  assign rs  = {r_i, din_i};
  assign q_o = (rs >= {1'b0, d_i});
  // The remainder is always below the divisor, so W bits hold it after the subtract.
  assign r_o = q_o ? W'(rs - {1'b0, d_i}) : rs[W-1:0];
endmodule

// File: rtl/pipe_ratio_div.sv
// Iterative ratio Q = IS*2^RF/IT, one quotient bit per clock, ival/irdy -> oval/ordy.
// Build option: PIPE_RATIO_DIV_ROUND_EN adds one guard bit and rounds half up.
module pipe_ratio_div
  import pipe_pkg::*;
#(
  parameter int QQ = DEF_QQ,
  parameter int SS = DEF_SS,
  parameter int RW = DEF_RW,
  parameter int RF = DEF_RF
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ival,
  output logic             irdy,
  input  logic             ieof,
  input  logic             isol,
  input  logic             ierr,
  input  logic [15:0]      ibk,
  input  logic [15:0]      iir,
  input  logic [QQ+SS-1:0] iis,
  input  logic [QQ+SS-1:0] iit,
  input  logic             ordy,
  output logic             oval,
  output logic             oeof,
  output logic             osol,
  output logic             oerr,
  output logic [15:0]      obk,
  output logic [15:0]      oir,
  output logic [RW-1:0]    oq
);
  localparam int W  = QQ + SS;
  localparam int SH = RW - RF;
  localparam int CW = $clog2(RW + 2);
`ifdef PIPE_RATIO_DIV_ROUND_EN
  localparam int NIT = RW + 1;
`else
  localparam int NIT = RW;
`endif

  div_st_t         st_q, st_d;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    r_q, it_q, r_nx, is_sh;
  logic [RW-1:0]   dv_q, res;
  logic [NIT-2:0]  q_q;
  logic [NIT-1:0]  q_nx;
  logic            qb, iack, zero, sat, last;
  logic            oeof_q, osol_q, oerr_q;
  logic [15:0]     obk_q, oir_q;
  logic [RW-1:0]   oq_q;

  assign oval  = (st_q == DONE);
  assign irdy  = (st_q == IDLE) | (oval & ordy);
  assign iack  = ival & irdy;
  assign is_sh = iis >> SH;
  assign zero  = (iit == '0);
  assign sat   = ~zero & (is_sh >= iit);
  assign last  = (cnt_q == CW'(NIT - 1));

  pipe_div_step #(.W(W)) u_step (
    .r_i   (r_q),
    .din_i (dv_q[RW-1]),
    .d_i   (it_q),
    .r_o   (r_nx),
    .q_o   (qb)
  );

  assign q_nx = {q_q, qb};

`ifdef PIPE_RATIO_DIV_ROUND_EN
  logic [RW:0] qr;
  // Low bit of the extended quotient is the half-LSB guard bit.
  assign qr  = {1'b0, q_nx[NIT-1:1]} + {{RW{1'b0}}, q_nx[0]};
  assign res = qr[RW] ? {RW{1'b1}} : qr[RW-1:0];
`else
  assign res = q_nx;
`endif

  always_comb begin
    st_d = st_q;
    case (st_q)
      CALC:    if (last) st_d = DONE;
      DONE:    if (ordy) st_d = IDLE;
      default: st_d = st_q;
    endcase
    if (iack) st_d = (zero | sat) ? DONE : CALC;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      r_q    <= '0;
      it_q   <= '0;
      dv_q   <= '0;
      q_q    <= '0;
      oq_q   <= '0;
      obk_q  <= '0;
      oir_q  <= '0;
      oeof_q <= 1'b0;
      osol_q <= 1'b0;
      oerr_q <= 1'b0;
    end else begin
      st_q <= st_d;
      if (st_q == CALC) begin
        r_q   <= r_nx;
        dv_q  <= {dv_q[RW-2:0], 1'b0};
        q_q   <= q_nx[NIT-2:0];
        cnt_q <= cnt_q + 1'b1;
        if (last) oq_q <= res;
      end
      // Accept only happens in IDLE or while the held output is leaving.
      if (iack) begin
        it_q   <= iit;
        r_q    <= is_sh;
        dv_q   <= {iis[SH-1:0], {RF{1'b0}}};
        q_q    <= '0;
        cnt_q  <= '0;
        obk_q  <= ibk;
        oir_q  <= iir;
        oeof_q <= ieof;
        osol_q <= isol;
        oerr_q <= ierr | zero;
        if (zero | sat) oq_q <= '1;
      end
    end
  end

  assign oq   = oq_q;
  assign obk  = obk_q;
  assign oir  = oir_q;
  assign oeof = oeof_q;
  assign osol = osol_q;
  assign oerr = oerr_q;
endmodule

// File: tb/tb_pipe_ratio_div.sv
// Directed bench for pipe_ratio_div; expectations follow PIPE_RATIO_DIV_ROUND_EN if defined.
module tb_pipe_ratio_div;
  localparam int QQ = 12, SS = 11, RW = 16, RF = 12, W = QQ + SS;
  // Latency = number of falling edges from the accept edge until oval is seen high.
`ifdef PIPE_RATIO_DIV_ROUND_EN
  localparam int          LAT = RW + 2;
  localparam logic [15:0] Q23 = 16'd2731;
`else
  localparam int          LAT = RW + 1;
  localparam logic [15:0] Q23 = 16'd2730;
`endif

  logic          clk = 1'b0;
  logic          rst_n, ival, irdy, ieof, isol, ierr, ordy, oval, oeof, osol, oerr;
  logic [15:0]   ibk, iir, obk, oir;
  logic [W-1:0]  iis, iit;
  logic [RW-1:0] oq;
  int            n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  pipe_ratio_div #(.QQ(QQ), .SS(SS), .RW(RW), .RF(RF)) dut (
    .clk(clk), .rst_n(rst_n), .ival(ival), .irdy(irdy), .ieof(ieof), .isol(isol),
    .ierr(ierr), .ibk(ibk), .iir(iir), .iis(iis), .iit(iit), .ordy(ordy),
    .oval(oval), .oeof(oeof), .osol(osol), .oerr(oerr), .obk(obk), .oir(oir), .oq(oq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [W-1:0] s, input logic [W-1:0] t, input logic e,
                       input logic eo, input logic so, input logic [15:0] bk, input logic [15:0] ir);
    iis = s; iit = t; ierr = e; ieof = eo; isol = so; ibk = bk; iir = ir; ival = 1'b1;
  endtask

  // Garbage on the inputs after accept exposes any use of live inputs.
  task automatic scramble();
    ival = 1'b0; iis = '1; iit = '0; ierr = ~ierr; ieof = ~ieof; isol = ~isol;
    ibk = ~ibk; iir = ~iir;
  endtask

  task automatic accept(input string tag);
    int to = 0;
    while (!irdy && to < 50) begin @(negedge clk); to++; end
    chk({tag, "_irdy"}, 32'(irdy), 32'd1);
    @(posedge clk); #1;
    scramble();
  endtask

  task automatic wait_oval(input string tag, input int exp_lat);
    int lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (oval) begin lat = k; break; end
    end
    chk({tag, "_lat"}, lat, exp_lat);
  endtask

  task automatic check_out(input string tag, input logic [15:0] q, input logic e, input logic eo,
                           input logic so, input logic [15:0] bk, input logic [15:0] ir);
    chk({tag, "_oq"},   32'(oq),   32'(q));
    chk({tag, "_oerr"}, 32'(oerr), 32'(e));
    chk({tag, "_oeof"}, 32'(oeof), 32'(eo));
    chk({tag, "_osol"}, 32'(osol), 32'(so));
    chk({tag, "_obk"},  32'(obk),  32'(bk));
    chk({tag, "_oir"},  32'(oir),  32'(ir));
  endtask

  task automatic pop(input string tag);
    ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
    chk({tag, "_pop"}, 32'(oval), 32'd0);
  endtask

  task automatic one(input string tag, input logic [W-1:0] s, input logic [W-1:0] t, input logic e,
                     input logic eo, input logic so, input logic [15:0] bk, input logic [15:0] ir,
                     input logic [15:0] q, input logic oe, input int lat);
    @(negedge clk);
    drive(s, t, e, eo, so, bk, ir);
    accept(tag);
    wait_oval(tag, lat);
    check_out(tag, q, oe, eo, so, bk, ir);
    pop(tag);
  endtask

  initial begin
    rst_n = 1'b0; ordy = 1'b0; ival = 1'b0; ieof = 1'b0; isol = 1'b0; ierr = 1'b0;
    ibk = '0; iir = '0; iis = '0; iit = '0;
    #12;
    chk("rst_oval", 32'(oval), 32'd0);
    chk("rst_irdy", 32'(irdy), 32'd1);
    check_out("rst", 16'd0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    @(negedge clk); rst_n = 1'b1;

    one("r1000", 23'd1000, 23'd4000, 1'b1, 1'b1, 1'b1, 16'h0ABC, 16'h0123, 16'd1024, 1'b1, LAT);
    one("r2_3",  23'd2,    23'd3,    1'b0, 1'b0, 1'b0, 16'h1111, 16'h2222, Q23,      1'b0, LAT);
    one("r1_3",  23'd1,    23'd3,    1'b0, 1'b1, 1'b0, 16'h3333, 16'h4444, 16'd1365, 1'b0, LAT);
    one("sat",   23'd16,   23'd1,    1'b0, 1'b0, 1'b1, 16'h5555, 16'h6666, 16'hFFFF, 1'b0, 1);
    one("zero",  23'd5,    23'd0,    1'b0, 1'b1, 1'b1, 16'h7777, 16'h8888, 16'hFFFF, 1'b1, 1);
    one("is0",   23'd0,    23'd7,    1'b0, 1'b0, 1'b0, 16'h0001, 16'h0002, 16'd0,    1'b0, LAT);
    one("r15_1", 23'd15,   23'd1,    1'b0, 1'b0, 1'b0, 16'h0003, 16'h0004, 16'hF000, 1'b0, LAT);

    // Back-to-back: A held for 5 clocks with B waiting, then both move on one edge.
    @(negedge clk);
    drive(23'd1000, 23'd4000, 1'b0, 1'b0, 1'b1, 16'h00AA, 16'h0A0A);
    accept("bb_a");
    wait_oval("bb_a", LAT);
    drive(23'd2, 23'd3, 1'b0, 1'b1, 1'b0, 16'h00BB, 16'h0B0B);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bb_hold_oval", 32'(oval), 32'd1);
      chk("bb_hold_irdy", 32'(irdy), 32'd0);
      chk("bb_hold_oq",   32'(oq),   32'd1024);
      chk("bb_hold_obk",  32'(obk),  32'h00AA);
    end
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    scramble();
    @(negedge clk);
    chk("bb_swap_oval", 32'(oval), 32'd0);
    chk("bb_swap_irdy", 32'(irdy), 32'd0);
    wait_oval("bb_b", LAT - 1);
    check_out("bb_b", Q23, 1'b0, 1'b1, 1'b0, 16'h00BB, 16'h0B0B);
    pop("bb_b");
    repeat (3) begin
      @(negedge clk);
      chk("bb_nodup", 32'(oval), 32'd0);
    end

    // Reset while calculating.
    @(negedge clk);
    drive(23'd1000, 23'd4000, 1'b0, 1'b1, 1'b1, 16'h0C0C, 16'h0D0D);
    accept("rc");
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rc_oval", 32'(oval), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("rc_irdy", 32'(irdy), 32'd1);
    repeat (20) @(negedge clk);
    chk("rc_drop", 32'(oval), 32'd0);

    // Reset while holding a finished record.
    @(negedge clk);
    drive(23'd16, 23'd1, 1'b0, 1'b1, 1'b0, 16'h0E0E, 16'h0F0F);
    accept("rd");
    wait_oval("rd", 1);
    #2 rst_n = 1'b0;
    #1 chk("rd_oval", 32'(oval), 32'd0);
    chk("rd_oq", 32'(oq), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("rd_irdy", 32'(irdy), 32'd1);

    one("post", 23'd1, 23'd3, 1'b1, 1'b0, 1'b1, 16'h1234, 16'h5678, 16'd1365, 1'b1, LAT);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
